// File: rtl/ti_sif_pkg.sv
// Shared types for the ti_sif configuration sequencer: FSM states, table-entry layout, index width helper.
package ti_sif_pkg;
    localparam int SIF_ADDR_BITS = 8;
    localparam int SIF_DATA_BITS = 8;
    localparam int DLY_BITS      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_HOST_ISSUE,
        ST_HOST_WAIT
    } seq_state_t;

    typedef struct packed {
        logic                     last;
        logic [DLY_BITS-1:0]      delay;
        logic [SIF_ADDR_BITS-1:0] addr;
        logic [SIF_DATA_BITS-1:0] data;
    } tbl_entry_t;

    function automatic int tbl_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/ti_sif_cfg_dly_cntr.sv
// Loadable down-counter; o_done is high in the enabled cycle that holds the count at 1,
// so a load of N followed by N enabled cycles fires on the N-th.
module ti_sif_cfg_dly_cntr #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_arst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_en,
    output logic         o_done
);
    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)
            cnt <= '0;
        else if (i_load)
            cnt <= i_val;
        else if (i_en && cnt > W'(1))
            cnt <= cnt - W'(1);
    end

    assign o_done = i_en && !i_load && (cnt == W'(1));
endmodule

// File: rtl/ti_sif_cfg_seq.sv
// Register-table sequencer in front of one ti_sif write engine, with host single-write access.
// Define TI_SIF_SEQ_TIMEOUT_EN to build the o_sif_load -> i_sif_done watchdog.
module ti_sif_cfg_seq
    import ti_sif_pkg::*;
#(
    parameter  int P_TBL_DEPTH     = 64,
    parameter  int P_SIF_ADDR_BITS = SIF_ADDR_BITS,
    parameter  int P_SIF_DATA_BITS = SIF_DATA_BITS,
    parameter  int P_DLY_BITS      = DLY_BITS,
    parameter  int P_TIMEOUT       = 4096,
    localparam int TBL_AW          = tbl_aw(P_TBL_DEPTH),
    localparam int TBL_W           = 1 + P_DLY_BITS + P_SIF_ADDR_BITS + P_SIF_DATA_BITS
) (
    input  logic                       i_clk,
    input  logic                       i_arst,
    input  logic                       i_start,
    output logic [TBL_AW-1:0]          o_tbl_addr,
    input  logic [TBL_W-1:0]           i_tbl_data,
    input  logic                       i_host_req,
    input  logic [P_SIF_ADDR_BITS-1:0] i_host_addr,
    input  logic [P_SIF_DATA_BITS-1:0] i_host_data,
    output logic                       o_host_ack,
    output logic                       o_sif_load,
    output logic [P_SIF_ADDR_BITS-1:0] o_sif_addr,
    output logic [P_SIF_DATA_BITS-1:0] o_sif_data,
    input  logic                       i_sif_done,
    output logic                       o_busy,
    output logic                       o_cfg_done,
    output logic                       o_err,
    output logic [TBL_AW:0]            o_entry_cnt
);
    seq_state_t                 state_q, state_d;
    logic [TBL_AW-1:0]          idx_q;
    logic                       fetch_ph;
    logic                       ent_last;
    logic [P_DLY_BITS-1:0]      ent_dly;
    logic [P_SIF_ADDR_BITS-1:0] ent_addr;
    logic [P_SIF_DATA_BITS-1:0] ent_data;
    logic [TBL_AW:0]            ent_cnt;
    logic                       cfg_done_q;
    logic                       sif_load, host_ack, dly_load, advance, idx_inc, cfg_set;
    logic                       dly_expire, wd_expire;

    ti_sif_cfg_dly_cntr #(.W(P_DLY_BITS)) u_dly (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_load (dly_load),
        .i_val  (ent_dly),
        .i_en   (state_q == ST_DELAY),
        .o_done (dly_expire)
    );

`ifdef TI_SIF_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(P_TIMEOUT + 1);
    logic err_q;

    // Armed by every load; only counts while a write is outstanding.
    ti_sif_cfg_dly_cntr #(.W(WD_W)) u_wdog (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_load (sif_load),
        .i_val  (WD_W'(P_TIMEOUT)),
        .i_en   (state_q == ST_WAIT_DONE || state_q == ST_HOST_WAIT),
        .o_done (wd_expire)
    );

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)
            err_q <= 1'b0;
        else if (state_q == ST_IDLE && i_start)
            err_q <= 1'b0;
        else if (wd_expire && !i_sif_done)
            err_q <= 1'b1;
    end

    assign o_err = err_q;
`else
    assign wd_expire = 1'b0;
    assign o_err     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sif_load = 1'b0;
        host_ack = 1'b0;
        dly_load = 1'b0;
        advance  = 1'b0;
        idx_inc  = 1'b0;
        cfg_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start)
                    state_d = ST_FETCH;
                else if (i_host_req)
                    state_d = ST_HOST_ISSUE;
            end
            ST_FETCH: if (fetch_ph) state_d = ST_ISSUE;
            ST_ISSUE: begin
                sif_load = 1'b1;
                state_d  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_sif_done) begin
                    if (ent_dly != '0) begin
                        dly_load = 1'b1;
                        state_d  = ST_DELAY;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELAY: if (dly_expire) advance = 1'b1;
            ST_HOST_ISSUE: begin
                sif_load = 1'b1;
                state_d  = ST_HOST_WAIT;
            end
            ST_HOST_WAIT: begin
                if (i_sif_done || wd_expire) begin
                    host_ack = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The index never wraps: the last table slot ends the run even without last=1.
        if (advance) begin
            if (ent_last || idx_q == TBL_AW'(P_TBL_DEPTH - 1)) begin
                state_d = ST_IDLE;
                cfg_set = 1'b1;
            end else begin
                state_d = ST_FETCH;
                idx_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            fetch_ph   <= 1'b0;
            ent_last   <= 1'b0;
            ent_dly    <= '0;
            ent_addr   <= '0;
            ent_data   <= '0;
            ent_cnt    <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Table read data lands one cycle after the address, so FETCH spans two cycles.
            fetch_ph <= (state_q == ST_FETCH) && !fetch_ph;
            if (state_q == ST_IDLE && i_start) begin
                idx_q      <= '0;
                ent_cnt    <= '0;
                cfg_done_q <= 1'b0;
            end
            if (idx_inc)
                idx_q <= idx_q + TBL_AW'(1);
            if (state_q == ST_FETCH && fetch_ph) begin
                ent_data <= i_tbl_data[P_SIF_DATA_BITS-1:0];
                ent_addr <= i_tbl_data[P_SIF_DATA_BITS +: P_SIF_ADDR_BITS];
                ent_dly  <= i_tbl_data[P_SIF_DATA_BITS+P_SIF_ADDR_BITS +: P_DLY_BITS];
                ent_last <= i_tbl_data[TBL_W-1];
            end
            if (state_q == ST_WAIT_DONE && i_sif_done)
                ent_cnt <= ent_cnt + (TBL_AW+1)'(1);
            if (cfg_set)
                cfg_done_q <= 1'b1;
        end
    end

    assign o_tbl_addr  = idx_q;
    assign o_sif_load  = sif_load;
    assign o_sif_addr  = (state_q == ST_HOST_ISSUE) ? i_host_addr : ent_addr;
    assign o_sif_data  = (state_q == ST_HOST_ISSUE) ? i_host_data : ent_data;
    assign o_host_ack  = host_ack;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_cfg_done  = cfg_done_q;
    assign o_entry_cnt = ent_cnt;
endmodule

// File: doc/ti_sif_cfg_seq.md
Name: ti_sif_cfg_seq

Overview:
Configuration sequencer that drives one ti_sif serial write engine. On a start request it walks an external register table (ROM or BRAM) and issues each {addr, data} write in order. It can insert a per-entry post-write delay. Between table runs it also services single-write requests from a host and arbitrates them against table playback. It sits between the board-bringup / control fabric and the ti_sif instance that configures the TI device.

Parameters:
P_TBL_DEPTH, 64, number of table entries; table address width TBL_AW = $clog2(P_TBL_DEPTH)
P_SIF_ADDR_BITS, 8, SIF register address width (matches ti_sif)
P_SIF_DATA_BITS, 8, SIF register data width (matches ti_sif)
P_DLY_BITS, 16, width of the per-entry post-write delay field, in i_clk cycles
P_TIMEOUT, 4096, i_clk cycles allowed from o_sif_load to i_sif_done (used only with TI_SIF_SEQ_TIMEOUT_EN)

Ports:
i_clk  input  1  clock; all logic is in this single domain
i_arst  input  1  asynchronous active-high reset
i_start  input  1  pulse; starts table playback at entry 0; ignored unless FSM is IDLE
o_tbl_addr  output  TBL_AW  table read address
i_tbl_data  input  1+P_DLY_BITS+P_SIF_ADDR_BITS+P_SIF_DATA_BITS  table word {last, delay, addr, data}; valid exactly 1 cycle after o_tbl_addr changes
i_host_req  input  1  host write request; held high until o_host_ack
i_host_addr  input  P_SIF_ADDR_BITS  host write address; stable while i_host_req is high
i_host_data  input  P_SIF_DATA_BITS  host write data; stable while i_host_req is high
o_host_ack  output  1  1-cycle pulse when the host write's i_sif_done is received
o_sif_load  output  1  1-cycle pulse to ti_sif
o_sif_addr  output  P_SIF_ADDR_BITS  to ti_sif; valid when o_sif_load is high
o_sif_data  output  P_SIF_DATA_BITS  to ti_sif; valid when o_sif_load is high
i_sif_done  input  1  done pulse from ti_sif
o_busy  output  1  high in every state except IDLE
o_cfg_done  output  1  sticky; set when the entry with last=1 completes; cleared by i_start
o_err  output  1  sticky timeout flag; cleared by i_start
o_entry_cnt  output  TBL_AW+1  number of table entries completed in the current run

Behaviour:
- Reset (async assert, sync deassert handled upstream): FSM=IDLE, all outputs 0, tbl index=0.
- States: IDLE, FETCH, ISSUE, WAIT_DONE, DELAY, HOST_ISSUE, HOST_WAIT.
- IDLE transitions:
  - i_start → clear o_cfg_done, o_err, o_entry_cnt; index=0; go to FETCH.
  - Else if i_host_req → go to HOST_ISSUE.
  - i_start has priority if both are high in the same cycle.
- FETCH: drive o_tbl_addr=index; wait 1 cycle; capture i_tbl_data; go to ISSUE.
- ISSUE: o_sif_load=1 for exactly 1 cycle with the captured addr/data; go to WAIT_DONE.
- WAIT_DONE: on i_sif_done, o_entry_cnt++.
  - If delay≠0, load delay counter and go to DELAY.
  - Else if last=1 or index==P_TBL_DEPTH-1, set o_cfg_done and go to IDLE.
  - Else index++ and go to FETCH.
- DELAY: count down to 1; on expiry apply the same last / next rule as WAIT_DONE.
  - Delay of N means N cycles in DELAY.
- Host access is served only from IDLE. i_host_req raised during a run waits until the run ends.
- HOST_ISSUE: one-cycle o_sif_load with i_host_addr/i_host_data; go to HOST_WAIT.
- HOST_WAIT: on i_sif_done, pulse o_host_ack and return to IDLE.
  - A still-high i_host_req in the ack cycle is not re-served until the next cycle, after the requester has deasserted.
- The table index never wraps: the end of the table terminates the run even if last=0.
- i_start while busy: ignored.
- A stray i_sif_done in IDLE, FETCH, ISSUE or DELAY: ignored.
- o_sif_load is never asserted while a write is outstanding.

Optional Feature:
TI_SIF_SEQ_TIMEOUT_EN.
- Defined: a watchdog counts from o_sif_load in WAIT_DONE/HOST_WAIT. At P_TIMEOUT cycles it sets o_err and returns to IDLE; the run is aborted and o_cfg_done stays 0. A host timeout still pulses o_host_ack.
- Undefined: no counter is built; o_err is tied 0; WAIT states wait indefinitely.

Decomposition:
- Package ti_sif_pkg holds:
  - the FSM state enum;
  - a typedef for the packed table-entry struct {last, delay, addr, data}, parameterised via localparams;
  - the TBL_AW helper.
- One sub-module, ti_sif_cfg_dly_cntr: a loadable down-counter with a done pulse, reused for both DELAY and the watchdog.

Test Plan:
- 3-entry table {0x01:0xA5}, {0x02:0x5A}, {0x03:0xFF, last=1}, no delays, start → exactly 3 loads in order; o_entry_cnt=3; o_cfg_done=1; o_busy falls 1 cycle after the 3rd done.
- Entry 0 with delay=10 → second o_sif_load occurs ≥10 cycles after the first i_sif_done.
- Host req addr=0x40 data=0x12 raised mid-run → served only after o_cfg_done; single o_host_ack; exactly one host load.
- i_start and i_host_req high in the same IDLE cycle → table runs first, host is served after.
- TIMEOUT_EN with i_sif_done withheld → o_err=1 after 4096 cycles, back in IDLE, o_cfg_done=0.
- i_arst asserted in WAIT_DONE → all outputs 0 immediately; a new start replays from entry 0.
